// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state codes and sizing constants for the stopwatch sequencer.
package stopwatch_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      PAUSE    = 3'd2,
      LAP_HOLD = 3'd3,
      RECALL   = 3'd4
   } state_t;
   localparam int LAP_DEPTH_DEF = 4;
   localparam int TIME_W = 16;
endpackage

// File: rtl/lap_buffer.sv
// lap_buffer: circular oldest-first store of lap times with saturating count and read-by-index.
module lap_buffer
   import stopwatch_pkg::*;
#(
   parameter int DEPTH = LAP_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              clr,
   input  logic [TIME_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_idx,
   output logic [TIME_W-1:0] rd_data,
   output logic [CW-1:0]     count
);
   logic [TIME_W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   function automatic logic [AW-1:0] wrap(input logic [AW:0] v);
      logic [AW:0] s;
      s = v >= (AW+1)'(DEPTH) ? v - (AW+1)'(DEPTH) : v;
      return s[AW-1:0];
   endfunction
   // rp tracks the oldest surviving entry, advancing only once the store is full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || clr) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (push) begin
         wp <= wrap({1'b0, wp} + (AW+1)'(1));
         if (count == CW'(DEPTH)) rp <= wrap({1'b0, rp} + (AW+1)'(1));
         else count <= count + CW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (rst && !clr && push) mem[wp] <= wr_data;
   end
   assign rd_data = mem[wrap({1'b0, rp} + {1'b0, rd_idx})];
endmodule

// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer: start/pause/lap/recall control FSM driving counter enables, display and lap LEDs.
module stopwatch_sequencer
   import stopwatch_pkg::*;
#(
   parameter int LAP_DEPTH = LAP_DEPTH_DEF,
   localparam int AW = $clog2(LAP_DEPTH),
   localparam int CW = $clog2(LAP_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pb_start,
   input  logic                 pb_lap,
   input  logic [7:0]           min_in,
   input  logic [7:0]           sec_in,
   output logic                 cnt_en,
   output logic                 cnt_clr,
   output logic [TIME_W-1:0]    disp,
   output logic [2:0]           state,
   output logic [LAP_DEPTH-1:0] led
);
   state_t st;
   logic [AW-1:0] idx;
   logic [TIME_W-1:0] hold, rd_data;
   logic [CW-1:0] count;
   logic lap_ev, push, clr, last;
   logic [LAP_DEPTH-1:0] led_n;
   assign state  = st;
   assign lap_ev = pb_lap && !pb_start;
   assign last   = CW'(idx) + CW'(1) == count;
   assign push   = lap_ev && st == RUN;
   assign clr    = lap_ev && ((st == PAUSE && count == '0) || (st == RECALL && last));
   always_comb begin
      led_n = '0;
      for (int i = 0; i < LAP_DEPTH; i++)
         led_n[i] = st == RECALL ? idx == AW'(i) : CW'(i) < count;
   end
   lap_buffer #(.DEPTH(LAP_DEPTH)) u_buf (
      .clk(clk), .rst(rst), .push(push), .clr(clr), .wr_data({min_in, sec_in}),
      .rd_idx(idx), .rd_data(rd_data), .count(count)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st      <= IDLE;
         idx     <= '0;
         hold    <= '0;
         cnt_en  <= 1'b0;
         cnt_clr <= 1'b0;
         disp    <= '0;
         led     <= '0;
      end else begin
         cnt_en  <= st == RUN || st == LAP_HOLD;
         cnt_clr <= clr;
         disp    <= st == LAP_HOLD ? hold : st == RECALL ? rd_data : {min_in, sec_in};
         led     <= led_n;
         if (pb_start) begin
            st <= (st == IDLE || st == PAUSE) ? RUN : PAUSE;
         end else if (pb_lap) begin
            case (st)
               RUN: begin
                  st   <= LAP_HOLD;
                  hold <= {min_in, sec_in};
               end
               LAP_HOLD: st <= RUN;
               PAUSE: begin
                  st  <= count == '0 ? IDLE : RECALL;
                  idx <= '0;
               end
               RECALL: begin
                  st  <= last ? IDLE : RECALL;
                  idx <= last ? '0 : idx + AW'(1);
               end
               default: st <= st;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb_stopwatch_sequencer: queue-scoreboard bench comparing the sequencer with a lap-list reference model.
module tb_stopwatch_sequencer;
   localparam int D = 4;
   logic clk = 0, rst = 0, pb_start = 0, pb_lap = 0;
   logic [7:0] min_in = 0, sec_in = 0;
   logic cnt_en, cnt_clr;
   logic [15:0] disp;
   logic [2:0] state;
   logic [D-1:0] led;

   stopwatch_sequencer #(.LAP_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .pb_start(pb_start), .pb_lap(pb_lap), .min_in(min_in),
      .sec_in(sec_in), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .disp(disp), .state(state), .led(led)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic en;
      logic clr;
      logic [15:0] disp;
      logic [D-1:0] led;
   } exp_t;
   exp_t q[$];
   int n_cmp = 0, n_bad = 0, cyc_n = 0;

   // Reference: laps kept as a plain list, oldest at the front
   int m_st = 0, m_idx = 0;
   logic [15:0] m_hold = 0;
   logic [15:0] laps[$];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc_n, a, e);
      end
   endtask

   task automatic cyc(input bit r, input bit s, input bit l, input logic [15:0] t);
      exp_t e;
      int n;
      @(negedge clk);
      rst = r; pb_start = s; pb_lap = l; {min_in, sec_in} = t;
      e = '0;
      if (!r) begin
         m_st = 0; m_idx = 0; m_hold = 0; laps.delete();
      end else begin
         n = laps.size();
         e.en   = (m_st == 1 || m_st == 3);
         e.disp = m_st == 3 ? m_hold : m_st == 4 ? laps[m_idx] : t;
         e.led  = m_st == 4 ? D'(1 << m_idx) : D'((1 << n) - 1);
         if (s) m_st = (m_st == 0 || m_st == 2) ? 1 : 2;
         else if (l) begin
            if (m_st == 1) begin
               laps.push_back(t);
               if (laps.size() > D) void'(laps.pop_front());
               m_hold = t; m_st = 3;
            end else if (m_st == 3) m_st = 1;
            else if (m_st == 2) begin
               if (n > 0) begin m_st = 4; m_idx = 0; end
               else begin m_st = 0; e.clr = 1; end
            end else if (m_st == 4) begin
               if (m_idx < n - 1) m_idx++;
               else begin m_st = 0; m_idx = 0; e.clr = 1; laps.delete(); end
            end
         end
         if (e.clr) laps.delete();
         e.st = 3'(m_st);
      end
      q.push_back(e);
   endtask

   function automatic logic [15:0] rnd_time();
      return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
   endfunction

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1, 0, 0, rnd_time());
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc_n++;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("cnt_en", 32'(cnt_en), 32'(e.en));
            chk("cnt_clr", 32'(cnt_clr), 32'(e.clr));
            chk("disp", 32'(disp), 32'(e.disp));
            chk("led", 32'(led), 32'(e.led));
         end
      end
   end

   initial begin
      repeat (3) cyc(0, 0, 0, 16'h0000);
      idle(3);
      // basic lap at 01:23 then back to run
      cyc(1, 1, 0, 16'h0000);
      idle(2);
      cyc(1, 0, 1, 16'h0123);
      idle(3);
      cyc(1, 0, 1, 16'h0200);
      idle(3);
      // pause, recall the single lap, exit with clear
      cyc(1, 1, 0, 16'h0000); idle(1);
      cyc(1, 0, 1, 16'h0000); idle(2);
      cyc(1, 0, 1, 16'h0000); idle(2);
      // overflow: five laps, oldest dropped
      cyc(1, 1, 0, 16'h0000); idle(1);
      for (int k = 1; k <= 5; k++) begin
         cyc(1, 0, 1, 16'(k)); idle(1);
         cyc(1, 0, 1, 16'h0000); idle(1);
      end
      cyc(1, 1, 0, 16'h0000); idle(1);
      for (int k = 0; k < 5; k++) begin
         cyc(1, 0, 1, 16'h0000); idle(2);
      end
      // pause clear with no laps
      cyc(1, 1, 0, 16'h0000); idle(1);
      cyc(1, 1, 0, 16'h0000); idle(1);
      cyc(1, 0, 1, 16'h0000); idle(3);
      // simultaneous pulses in RUN
      cyc(1, 1, 0, 16'h0000); idle(1);
      cyc(1, 0, 1, 16'h0111); idle(1);
      cyc(1, 0, 1, 16'h0000); idle(1);
      cyc(1, 1, 1, 16'h0222); idle(2);
      // reset while in RECALL at index 1
      cyc(1, 1, 0, 16'h0000); idle(1);
      cyc(1, 0, 1, 16'h0333); idle(1);
      cyc(1, 0, 1, 16'h0000); idle(1);
      cyc(1, 1, 0, 16'h0000); idle(1);
      cyc(1, 0, 1, 16'h0000); idle(1);
      cyc(1, 0, 1, 16'h0000); idle(1);
      cyc(0, 0, 0, 16'h0000);
      cyc(0, 0, 0, 16'h0000);
      idle(4);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 299) != 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0, rnd_time());
      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
